// File: rtl/exec_pkg.sv
// Shared op-code and FSM state encodings plus default widths for the execute stage.
package exec_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_BUSY = 2'b01,
    ST_HOLD     = 2'b10
  } exec_state_e;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier returning the low DATA_W bits of the unsigned product.
// One multiplier bit per cycle; done is a combinational pulse in the last iteration with product valid alongside.
module seq_mul #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc_next;

  // The final partial sum is exposed combinationally so the caller registers it at the DATA_W-th edge.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == CNT_W'(DATA_W - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/execute_stage_pipe.sv
// Execute stage: single-cycle ALU ops, DATA_W-cycle iterative MUL, registered valid/ready result channel.
// Latency 1 (non-MUL) or DATA_W (MUL); in_ready drops while multiplying or while a result is stalled.
module execute_stage_pipe
  import exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic [DATA_W-1:0] imm,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf,
  output logic [REG_W-1:0]  wr_reg
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int MSB     = DATA_W - 1;

  exec_state_e       state;
  alu_op_e           op;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [REG_W-1:0]  dst_sel;

  assign op        = alu_op_e'(alu_op);
  assign opa       = rd1;
  assign opb       = alu_src ? imm : rd2;
  assign shamt     = opb[SHAMT_W-1:0];
  assign dst_sel   = reg_dst ? rd : rt;
  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = opa + opb;
        alu_ovf = (opa[MSB] == opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        alu_res = opa - opb;
        alu_ovf = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SLL:  alu_res = opa << shamt;
      OP_SRA:  alu_res = $signed(opa) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  seq_mul #(.DATA_W(DATA_W)) u_seq_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      wr_reg    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wr_reg <= dst_sel;
            if (op == OP_MUL) begin
              // Output slot is empty or draining this edge, so it is free for the whole multiply.
              state     <= ST_MUL_BUSY;
              out_valid <= 1'b0;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              ovf       <= alu_ovf;
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end else if (out_valid) begin
            state <= ST_HOLD;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done) begin
            result    <= mul_product;
            zero      <= (mul_product == '0);
            ovf       <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Directed table-driven bench for execute_stage_pipe at DATA_W=16 with hand-computed results.
module tb_execute_stage_pipe;

  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alu_op;
  logic          alu_src;
  logic          reg_dst;
  logic [DW-1:0] rd1, rd2, imm;
  logic [RW-1:0] rt, rd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          zero;
  logic          ovf;
  logic [RW-1:0] wr_reg;

  int checks   = 0;
  int failures = 0;

  execute_stage_pipe #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .alu_src   (alu_src),
    .reg_dst   (reg_dst),
    .rd1       (rd1),
    .rd2       (rd2),
    .imm       (imm),
    .rt        (rt),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .wr_reg    (wr_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [2:0]    op;
    logic          src;
    logic          dst;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] im;
    logic [RW-1:0] t;
    logic [RW-1:0] d;
    logic [DW-1:0] exp_res;
    logic          exp_zero;
    logic          exp_ovf;
    logic [RW-1:0] exp_wr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic src, input logic dst,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] im,
                       input logic [RW-1:0] t, input logic [RW-1:0] d);
    alu_op   = op;
    alu_src  = src;
    reg_dst  = dst;
    rd1      = a;
    rd2      = b;
    imm      = im;
    rt       = t;
    rd       = d;
    in_valid = 1'b1;
  endtask

  task automatic run_mul(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] exp);
    int bad;
    bad = 0;
    @(negedge clk);
    chk({name, "_in_ready"}, in_ready, 1);
    drive(3'b111, 1'b0, 1'b1, a, b, 16'h0, 3'd1, 3'd6);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Sampled after edges k .. k+15: must be busy with nothing on the output.
    for (int i = 0; i < DW; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      if (i < DW - 1) @(negedge clk);
    end
    chk({name, "_busy_window_violations"}, bad, 0);
    @(negedge clk);
    chk({name, "_out_valid"}, out_valid, 1);
    chk({name, "_result"}, result, exp);
    chk({name, "_zero"}, zero, (exp == 0));
    chk({name, "_ovf"}, ovf, 0);
    chk({name, "_wr_reg"}, wr_reg, 6);
    chk({name, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] held;
    int            seen;

    vecs[0]  = '{"add_ovf",  3'b000, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 3'd2, 3'd6, 16'h8000, 1'b0, 1'b1, 3'd2};
    vecs[1]  = '{"sub_zero", 3'b001, 1'b1, 1'b1, 16'h1234, 16'h9999, 16'h1234, 3'd2, 3'd5, 16'h0000, 1'b1, 1'b0, 3'd5};
    vecs[2]  = '{"sub_ovf",  3'b001, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h0000, 3'd3, 3'd4, 16'h7FFF, 1'b0, 1'b1, 3'd3};
    vecs[3]  = '{"and",      3'b010, 1'b0, 1'b1, 16'hF0F0, 16'h3C3C, 16'h0000, 3'd1, 3'd7, 16'h3030, 1'b0, 1'b0, 3'd7};
    vecs[4]  = '{"or_imm",   3'b011, 1'b1, 1'b0, 16'h00F0, 16'hFFFF, 16'h0F00, 3'd4, 3'd0, 16'h0FF0, 1'b0, 1'b0, 3'd4};
    vecs[5]  = '{"slt_true", 3'b100, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 3'd1, 3'd2, 16'h0001, 1'b0, 1'b0, 3'd1};
    vecs[6]  = '{"slt_fals", 3'b100, 1'b0, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 3'd6, 3'd2, 16'h0000, 1'b1, 1'b0, 3'd6};
    vecs[7]  = '{"sll_mask", 3'b101, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'h0013, 3'd1, 3'd3, 16'h0008, 1'b0, 1'b0, 3'd3};
    vecs[8]  = '{"sra_neg",  3'b110, 1'b0, 1'b0, 16'h8000, 16'h0004, 16'h0000, 3'd5, 3'd1, 16'hF800, 1'b0, 1'b0, 3'd5};
    vecs[9]  = '{"add_wrap", 3'b000, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 3'd7, 3'd1, 16'h0000, 1'b1, 1'b0, 3'd7};
    vecs[10] = '{"sra_pos",  3'b110, 1'b1, 1'b0, 16'h7000, 16'h0000, 16'h0011, 3'd2, 3'd1, 16'h3800, 1'b0, 1'b0, 3'd2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(3'b000, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_wr_reg", wr_reg, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Single-cycle op table, one result per cycle.
    for (int i = 0; i < 11; i++) begin
      chk({vecs[i].name, "_in_ready"}, in_ready, 1);
      drive(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].t, vecs[i].d);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({vecs[i].name, "_out_valid"}, out_valid, 1);
      chk({vecs[i].name, "_result"}, result, vecs[i].exp_res);
      chk({vecs[i].name, "_zero"}, zero, vecs[i].exp_zero);
      chk({vecs[i].name, "_ovf"}, ovf, vecs[i].exp_ovf);
      chk({vecs[i].name, "_wr_reg"}, wr_reg, vecs[i].exp_wr);
    end
    @(negedge clk);
    chk("drain_out_valid_low", out_valid, 0);

    // Back-to-back SLT then SRA, accepted on consecutive edges.
    drive(3'b100, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0, 3'd1, 3'd2);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_slt_result", result, 16'h0001);
    chk("b2b_slt_in_ready", in_ready, 1);
    drive(3'b110, 1'b0, 1'b0, 16'h8000, 16'h0004, 16'h0, 3'd3, 3'd2);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_sra_out_valid", out_valid, 1);
    chk("b2b_sra_result", result, 16'hF800);
    chk("b2b_sra_wr_reg", wr_reg, 3);

    run_mul("mul_basic", 16'h0012, 16'h0034, 16'h03A8);
    run_mul("mul_trunc", 16'hFFFF, 16'hFFFF, 16'h0001);
    run_mul("mul_zero", 16'h1234, 16'h0000, 16'h0000);

    // Stall with out_ready low; a competing request must be ignored.
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'b011, 1'b0, 1'b0, 16'h1200, 16'h0034, 16'h0, 3'd4, 3'd0);
    @(posedge clk);
    @(negedge clk);
    held = result;
    chk("hold_or_result", held, 16'h1234);
    drive(3'b000, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0, 3'd0, 3'd7);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (result !== 16'h1234 || out_valid !== 1'b1 || in_ready !== 1'b0 || wr_reg !== 3'd4) seen++;
      @(negedge clk);
    end
    chk("hold_stable_violations", seen, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_release_out_valid", out_valid, 0);
    chk("hold_release_in_ready", in_ready, 1);
    chk("hold_result_unchanged", result, 16'h1234);

    // Reset eight cycles into a multiply.
    drive(3'b111, 1'b0, 1'b0, 16'h0012, 16'h0034, 16'h0, 3'd2, 3'd3);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_mul_rst_out_valid", out_valid, 0);
    chk("mid_mul_rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("mid_mul_no_result", seen, 0);
    chk("mid_mul_in_ready", in_ready, 1);
    drive(3'b000, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0, 3'd5, 3'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_add_valid", out_valid, 1);
    chk("post_rst_add_result", result, 16'h0007);
    chk("post_rst_add_wr", wr_reg, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage_pipe.md
EXECUTE_STAGE_PIPE -- requirements
Module: execute_stage_pipe

Interface
REQ-001 Parameter DATA_W, default 16, datapath width in bits (8..32).
REQ-002 Parameter REG_W, default 3, register-specifier width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  operation presented.
REQ-006 in_ready  out  1  stage can accept; transfer when in_valid && in_ready at a rising edge.
REQ-007 alu_op  in  3  operation code, see REQ-013.
REQ-008 alu_src  in  1  1: operand B = imm; 0: operand B = rd2.
REQ-009 reg_dst  in  1  1: destination = rd; 0: destination = rt.
REQ-010 rd1, rd2, imm  in  DATA_W each  register operands, sign-extended immediate.
REQ-011 rt, rd  in  REG_W each  candidate destination specifiers.
REQ-012 out_valid out 1; out_ready in 1; result out DATA_W; zero out 1; ovf out 1; wr_reg out REG_W  registered result channel, transfer when out_valid && out_ready.

Function
REQ-013 Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed, result 1/0), 101 SLL, 110 SRA, 111 MUL (low DATA_W bits of unsigned product).
REQ-014 Shift amount = low clog2(DATA_W) bits of operand B; upper bits ignored.
REQ-015 zero = (result == 0) for every op; ovf = signed overflow for ADD/SUB, 0 for all other ops.
REQ-016 wr_reg = reg_dst ? rd : rt, captured at accept.
REQ-017 States: IDLE, MUL_BUSY, HOLD.
REQ-018 in_ready = 1 only in IDLE and when (!out_valid || out_ready).
REQ-019 Non-MUL accepted at edge k: result/zero/ovf/wr_reg registered at edge k, out_valid = 1 after edge k (latency 1); state stays IDLE, enabling one op per cycle back-to-back.
REQ-020 MUL accepted at edge k: IDLE->MUL_BUSY, operands latched; iterative shift-add, one multiplier bit per cycle; 4-bit-wide-enough counter counts DATA_W iterations; result registered and out_valid = 1 after edge k+DATA_W; state -> IDLE.
REQ-021 MUL completion while out_valid && !out_ready: not possible by REQ-018; MUL entered only with output slot free or draining.
REQ-022 HOLD: entered when out_valid && !out_ready; all outputs stable, in_ready = 0; exit to IDLE on out_ready.
REQ-023 out_valid falls after a transfer edge unless a new result is registered at the same edge (simultaneous drain + accept keeps out_valid = 1 with new data).
REQ-024 in_valid while in_ready = 0 has no effect; inputs are not sampled.
REQ-025 Operand values X-free requirement only on transfer edges.

Reset
REQ-026 rst_n low forces immediately: state IDLE, out_valid 0, result 0, zero 0, ovf 0, wr_reg 0, MUL counter 0.
REQ-027 Reset mid-MUL abandons the operation; no result produced after release.
REQ-028 in_ready = 1 from first edge after rst_n deasserted.

Structure
REQ-029 Package exec_pkg holds the op-code enum, state enum and default-width constants.
REQ-030 One sub-module, seq_mul (DATA_W-parameterised iterative shift-add multiplier, start/done), instantiated once; all other ops combinational inside execute_stage_pipe.

Verification (DATA_W=16)
REQ-031 ADD rd1=0x7FFF, rd2=0x0001, alu_src=0 -> after 1 cycle result=0x8000, ovf=1, zero=0.
REQ-032 SUB rd1=0x1234, imm=0x1234, alu_src=1, reg_dst=1, rd=5 -> result=0x0000, zero=1, wr_reg=5.
REQ-033 MUL rd1=0x0012, rd2=0x0034 -> in_ready=0 for 16 cycles, out_valid after edge k+16, result=0x03A8.
REQ-034 Back-to-back SLT(0xFFFF,0x0001) then SRA(0x8000, shift 4) with out_ready=1 -> results 0x0001 then 0xF800 on consecutive cycles.
REQ-035 out_ready=0 for 5 cycles after OR result -> result constant, in_ready=0 throughout; release -> transfer, in_ready=1.
REQ-036 rst_n low 8 cycles into MUL -> out_valid=0 immediately, no result after release, next ADD correct.
